// File: rtl/inst_encoder.sv
// MIPS32 instruction encoder that streams encoded words into IMEM starting at a base address.
// Define ENC_BRANCH_ABS_EN to treat BEQ/BNE immediates as absolute word targets.
module inst_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {F_R, F_I, F_J} fmt_t;
    typedef enum logic [4:0] {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR,
        M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE,
        M_SLTI, M_SLTIU, M_J, M_JAL, M_ILLEGAL
    } mnem_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t      state;
    mnem_t       mnem;
    fmt_t        fmt;
    logic        out_last;
    logic        last_seen;
    logic        legal;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm16, br_imm;
    logic [31:0] enc_word;
    logic        fire, accept, load, end_hit, out_valid_nxt, go_done;

    assign mnem    = mnem_t'(in_mnem);
    assign fire    = imem_we & imem_ready;
    assign end_hit = fire & (imem_addr == LAST_ADDR);

    // Pass-through is blocked once the last word or the top address is in flight,
    // so no input is ever accepted that the session could not write.
    assign in_ready = (state == S_RUN) & ~last_seen &
                      (~imem_we | (imem_ready & (imem_addr != LAST_ADDR)));
    assign accept   = in_valid & in_ready;
    assign load     = accept & legal;

    assign out_valid_nxt = load | (imem_we & ~imem_ready);
    assign go_done       = end_hit | ((last_seen | (accept & in_last)) & ~out_valid_nxt);

`ifdef ENC_BRANCH_ABS_EN
    // A word accepted while the previous one drains lands one address further on.
    logic [ADDR_W-1:0] wr_addr_now;
    assign wr_addr_now = fire ? imem_addr + ADDR_W'(1) : imem_addr;
    assign br_imm      = 16'(in_imm[ADDR_W-1:0]) - 16'(wr_addr_now) - 16'd1;
`else
    assign br_imm = in_imm[15:0];
`endif

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        op    = 6'd0;
        funct = 6'd0;
        rs    = in_rs;
        rt    = in_rt;
        rd    = in_rd;
        sh    = 5'd0;
        imm16 = in_imm[15:0];
        fmt   = F_I;
        legal = 1'b1;
        case (mnem)
            M_ADD:   begin fmt = F_R; funct = 6'h20; end
            M_ADDU:  begin fmt = F_R; funct = 6'h21; end
            M_SUB:   begin fmt = F_R; funct = 6'h22; end
            M_SUBU:  begin fmt = F_R; funct = 6'h23; end
            M_AND:   begin fmt = F_R; funct = 6'h24; end
            M_OR:    begin fmt = F_R; funct = 6'h25; end
            M_XOR:   begin fmt = F_R; funct = 6'h26; end
            M_NOR:   begin fmt = F_R; funct = 6'h27; end
            M_SLT:   begin fmt = F_R; funct = 6'h2a; end
            M_SLTU:  begin fmt = F_R; funct = 6'h2b; end
            M_SLL:   begin fmt = F_R; funct = 6'h00; rs = 5'd0; sh = in_shamt; end
            M_SRL:   begin fmt = F_R; funct = 6'h02; rs = 5'd0; sh = in_shamt; end
            M_SRA:   begin fmt = F_R; funct = 6'h03; rs = 5'd0; sh = in_shamt; end
            M_SLLV:  begin fmt = F_R; funct = 6'h04; end
            M_SRLV:  begin fmt = F_R; funct = 6'h06; end
            M_SRAV:  begin fmt = F_R; funct = 6'h07; end
            M_JR:    begin fmt = F_R; funct = 6'h08; rt = 5'd0; rd = 5'd0; end
            M_ADDI:  op = 6'h08;
            M_ADDIU: op = 6'h09;
            M_ANDI:  op = 6'h0c;
            M_ORI:   op = 6'h0d;
            M_XORI:  op = 6'h0e;
            M_LUI:   begin op = 6'h0f; rs = 5'd0; end
            M_LW:    op = 6'h23;
            M_SW:    op = 6'h2b;
            M_BEQ:   begin op = 6'h04; imm16 = br_imm; end
            M_BNE:   begin op = 6'h05; imm16 = br_imm; end
            M_SLTI:  op = 6'h0a;
            M_SLTIU: op = 6'h0b;
            M_J:     begin fmt = F_J; op = 6'h02; end
            M_JAL:   begin fmt = F_J; op = 6'h03; end
            default: legal = 1'b0;
        endcase
        case (fmt)
            F_R:     enc_word = {6'd0, rs, rt, rd, sh, funct};
            F_J:     enc_word = {op, in_imm};
            default: enc_word = {op, rs, rt, imm16};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            out_last     <= 1'b0;
            last_seen    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (fire) begin
                        word_count <= word_count + (ADDR_W+1)'(1);
                        if (!end_hit) imem_addr <= imem_addr + ADDR_W'(1);
                    end
                    if (load) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= enc_word;
                        out_last   <= in_last;
                    end else if (fire) begin
                        imem_we <= 1'b0;
                    end
                    if (accept && !legal) err_illegal  <= 1'b1;
                    if (accept && in_last) last_seen   <= 1'b1;
                    if (end_hit && !out_last) err_overflow <= 1'b1;
                    if (go_done) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state        <= S_RUN;
                        imem_addr    <= base_addr;
                        imem_we      <= 1'b0;
                        word_count   <= '0;
                        last_seen    <= 1'b0;
                        out_last     <= 1'b0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
